// File: rtl/operand_queue_pkg.sv
// Shared definitions for the operand queue: default geometry, width helpers
// and the per-cycle request encoding used by the control block.
package operand_queue_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Bits needed to address DEPTH entries.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointers wrap by plain overflow, so DEPTH must be a power of two.
  function automatic bit is_pow2_ge2(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Request seen in one cycle, encoded as {load, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_LOAD = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/operand_queue_ctrl.sv
// Pointer, occupancy and error-flag bookkeeping for the operand queue.
// Flush outranks load/pop; the storage array lives in the parent.
module operand_queue_ctrl
  import operand_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH),
  localparam int unsigned CW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          wr_en_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_en;
  logic          valid;
  logic          full;
  op_e           op;

  assign op    = op_e'({load_i, pop_i});
  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // Next-state: flush clears everything, otherwise resolve the load/pop pair.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (op)
        OP_LOAD: begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        OP_POP: begin
          if (valid) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        OP_BOTH: begin
          // A full queue still accepts the load because the pop frees a slot.
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (valid) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            // No bypass: the pop has nothing to take, the load still lands.
            count_d     = CW'(1);
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en_o     = wr_en;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign valid_o     = valid;
  assign full_o      = full;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/operand_queue.sv
// DEPTH-entry operand FIFO between the memory buffer register and the ALU.
// Holds the storage array and the zero-when-empty head mux.
module operand_queue
  import operand_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH),
  localparam int unsigned CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
    $error("operand_queue: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  operand_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .pop_i       (pop),
    .flush_i     (flush),
    .wr_en_o     (wr_en),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .valid_o     (valid),
    .full_o      (full),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  // Operand storage; deliberately not reset, contents are guarded by valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= load_data;
    end
  end

  // Head is read from registered state only, so load_data never reaches it
  // in the same cycle.
  assign head_data = valid ? mem_q[rd_ptr] : '0;

endmodule

// File: tb/tb_operand_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a queue-based reference model. A WIDTH=8 instance shares the
// control inputs and must present the low byte of the same head.
module tb_operand_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] load_data = '0;

  logic [15:0] head_data;
  logic        valid, full, overflow, underflow;
  logic [2:0]  count;

  logic [7:0]  head8;
  logic        valid8, full8, overflow8, underflow8;
  logic [2:0]  count8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;

  always #5 clk = ~clk;

  operand_queue #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data),
    .pop(pop), .flush(flush), .head_data(head_data), .valid(valid),
    .full(full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  operand_queue #(.WIDTH(8), .DEPTH(DEPTH)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data[7:0]),
    .pop(pop), .flush(flush), .head_data(head8), .valid(valid8),
    .full(full8), .count(count8), .overflow(overflow8), .underflow(underflow8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_head();
    return (mq.size() > 0) ? mq[0] : 16'h0;
  endfunction

  // Apply one cycle of the queue rules to the model.
  task automatic model_step(input bit l, input bit p, input bit f, input logic [15:0] d);
    if (f) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (l && !p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
    end else if (p && !l) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_unf = 1;
    end else if (p && l) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        mq.push_back(d);
      end else begin
        mq.push_back(d);
        m_unf = 1;
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".count"},     32'(count),     32'(mq.size()));
    check_eq({tag, ".valid"},     32'(valid),     32'(mq.size() > 0));
    check_eq({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check_eq({tag, ".head"},      32'(head_data), 32'(m_head()));
    check_eq({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    check_eq({tag, ".head8"},     32'(head8),     32'(m_head() & 16'h00FF));
    check_eq({tag, ".count8"},    32'(count8),    32'(mq.size()));
  endtask

  // Drive one cycle, advance the model at the edge, then compare just after.
  task automatic cycle(input string tag, input bit l, input bit p, input bit f, input logic [15:0] d);
    load = l; pop = p; flush = f; load_data = d;
    @(posedge clk);
    model_step(l, p, f, d);
    #1;
    load = 0; pop = 0; flush = 0;
    $display("cycle %s load=%0b pop=%0b flush=%0b data=%04h -> count=%0d head=%04h ovf=%0b unf=%0b",
             tag, l, p, f, d, count, head_data, overflow, underflow);
    check_all(tag);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check_eq({tag, ".head_zero"}, 32'(head_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    check_eq("reset.count_zero", 32'(count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three consecutive loads
    cycle("ld0", 1, 0, 0, 16'h1234);
    check_eq("ld0.head_1234", 32'(head_data), 32'h1234);
    cycle("ld1", 1, 0, 0, 16'hABCD);
    cycle("ld2", 1, 0, 0, 16'h0F0F);
    check_eq("ld2.count3", 32'(count), 32'd3);
    check_eq("ld2.valid1", 32'(valid), 32'd1);

    // Fill, then overflow attempt
    cycle("ld3", 1, 0, 0, 16'h4444);
    cycle("ovf", 1, 0, 0, 16'hDEAD);
    check_eq("ovf.full", 32'(full), 32'd1);
    check_eq("ovf.flag", 32'(overflow), 32'd1);
    check_eq("ovf.count4", 32'(count), 32'd4);
    cycle("pop0", 0, 1, 0, 16'h0);
    check_eq("pop0.head", 32'(head_data), 32'hABCD);
    cycle("pop1", 0, 1, 0, 16'h0);
    cycle("pop2", 0, 1, 0, 16'h0);
    check_eq("pop2.head", 32'(head_data), 32'h4444);
    cycle("pop3", 0, 1, 0, 16'h0);
    check_eq("pop3.empty_head", 32'(head_data), 32'h0);
    check_eq("pop3.ovf_sticky", 32'(overflow), 32'd1);
    cycle("fl0", 0, 0, 1, 16'h0);

    // Simultaneous load+pop while full
    for (int i = 1; i <= 4; i++) cycle("fill", 1, 0, 0, 16'(i));
    cycle("both_full", 1, 1, 0, 16'h5555);
    check_eq("both_full.count4", 32'(count), 32'd4);
    check_eq("both_full.ovf0", 32'(overflow), 32'd0);
    check_eq("both_full.head2", 32'(head_data), 32'h0002);
    for (int i = 0; i < 3; i++) cycle("drain", 0, 1, 0, 16'h0);
    check_eq("drain.tail5555", 32'(head_data), 32'h5555);
    cycle("fl1", 0, 0, 1, 16'h0);

    // Underflow, then load+pop on empty
    cycle("unf", 0, 1, 0, 16'h0);
    check_eq("unf.flag", 32'(underflow), 32'd1);
    check_eq("unf.count0", 32'(count), 32'd0);
    check_eq("unf.head0", 32'(head_data), 32'h0);
    cycle("both_empty", 1, 1, 0, 16'h7777);
    check_eq("both_empty.count1", 32'(count), 32'd1);
    check_eq("both_empty.head", 32'(head_data), 32'h7777);

    // Flush wins over a concurrent load
    cycle("fl2", 0, 0, 1, 16'h0);
    for (int i = 0; i < 3; i++) cycle("pre_flush", 1, 0, 0, 16'hA000 + 16'(i));
    cycle("flush_load", 1, 0, 1, 16'h9999);
    check_eq("flush_load.count0", 32'(count), 32'd0);
    check_eq("flush_load.valid0", 32'(valid), 32'd0);
    check_eq("flush_load.head0", 32'(head_data), 32'h0);
    check_eq("flush_load.flags", 32'({overflow, underflow}), 32'd0);

    // Randomized traffic with one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      bit l, p, f;
      l = ($urandom_range(0, 99) < 55);
      p = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 63) == 0);
      cycle("rnd", l, p, f, 16'($urandom));
      if (i == 300) async_reset("midrst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_queue.md
# operand_queue

Parametrised operand buffer between the memory buffer register output and the ALU operand input. It supersedes the single-entry buffer register with a DEPTH-entry FIFO of WIDTH-bit operands, so several operands can be prefetched ahead of execution. It adds pop, flush, occupancy and error-flag behaviour. Load is driven by the same control-word bit that used to strobe the buffer register; pop is driven by the ALU-issue control bit.

## Interface
- WIDTH, 16, operand width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock; asserts immediately, deasserts synchronously to clk by upstream
- load  in  1  write load_data into tail this cycle
- load_data  in  WIDTH  operand from memory buffer register
- pop  in  1  consume head entry this cycle
- flush  in  1  discard all entries (branch/exception)
- head_data  out  WIDTH  operand at head; 0 when empty
- valid  out  1  queue non-empty
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: load attempted while full without pop
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH registers, write pointer wr_ptr and read pointer rd_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH naturally. count held as a separate register; full and valid are derived from count.
- Priority per cycle: reset > flush > load/pop.
- flush=1: wr_ptr, rd_ptr and count go to 0; overflow and underflow clear. load and pop are ignored that cycle. Storage contents are not cleared.
- load=1, pop=0:
  - not full: write mem[wr_ptr], wr_ptr+1, count+1.
  - full: write dropped, storage unchanged, overflow←1.
- pop=1, load=0:
  - non-empty: rd_ptr+1, count−1.
  - empty: no change, underflow←1.
- load=1, pop=1:
  - non-empty (including full): both are performed, count unchanged, no flag is set.
  - empty: load performed, pop ignored, underflow←1, count→1. There is no bypass, so the loaded data is not visible at head_data in the same cycle.
- head_data = valid ? mem[rd_ptr] : 0. This is a combinational read of registered state; there is no path from load_data to head_data within a cycle.
- Sticky flags hold until flush or reset.

## Timing
- Reset values: head_data=0, valid=0, full=0, count=0, overflow=0, underflow=0; pointers are 0. Storage is not reset.
- Load-to-use latency is 1 cycle. Data loaded at edge N is at head_data (if it is the head) after edge N, so it is usable in cycle N+1.
- Pop takes effect at the edge. head_data shows the next entry (or 0 if now empty) after that edge.
- All outputs change only at a clk rising edge or on rst_n assertion. There are no combinational input-to-output paths.
- Wrap-around: after DEPTH loads and DEPTH pops in any interleaving, pointers return to 0 and ordering is preserved.
- Reset mid-operation: all state returns to reset values immediately; contents are logically lost.

## Structure
- Shared package operand_queue_pkg: default WIDTH (16), default DEPTH (4), localparam function for the pointer width and count width.
- One sub-module is natural: operand_queue_ctrl, containing the pointers, count, flags and priority logic. The top level holds the storage array and the head mux.
- An elaboration-time check rejects a DEPTH that is not a power of two or is less than 2.

## Test plan
- Reset, then load 0x1234, 0xABCD, 0x0F0F on consecutive cycles -> count=3; head_data=0x1234 one cycle after the first load; valid=1.
- Fill to DEPTH=4, load 0xDEAD with pop=0 -> full=1, overflow=1, count=4. Then pop 4 times -> heads in original order; 0xDEAD is never seen.
- With the queue full, assert load=1 (0x5555) and pop=1 together -> count stays 4, old head is removed, 0x5555 becomes the tail, overflow remains 0.
- Empty queue, pop=1 alone -> underflow=1, count=0, head_data=0. Then load=1 and pop=1 together with 0x7777 -> count=1, head_data=0x7777 the next cycle.
- Load 3 entries, then assert flush and load together -> count=0, valid=0, both flags 0, head_data=0, and the flush-cycle load is dropped.
- Run 10 load/pop-interleaved operands through a DEPTH=4, WIDTH=8 instance -> output order matches input order across pointer wrap. Also assert rst_n mid-stream -> all outputs go to 0 immediately.
